// File: rtl/ahb_mem_slave.sv
// AHB-Lite word-organised memory slave with a configurable number of wait states
// and a two-cycle ERROR response for out-of-range, misaligned or oversized transfers.
module ahb_mem_slave #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [31:0] hrdata,
  output logic        hresp,
  output logic [2:0]  o_dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_wait_cnt;
  logic [1:0]    w_wait_cnt_next;
  logic [AW-1:0] r_idx;
  logic [3:0]    r_be;
  logic          r_write;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_oob;
  logic          w_misalign;
  logic          w_illegal;
  logic [3:0]    w_be;

  // Handshake: an address phase is taken only on an edge where hsel, hready and a
  // NONSEQ/SEQ htrans coincide while this slave is itself ready (hreadyout=1);
  // hreadyout=0 stretches the current data phase and blocks any new address phase.
  assign w_accept = hsel && hready && hreadyout &&
                    ((htrans == 2'b10) || (htrans == 2'b11));

  assign w_oob = ({2'b00, haddr[31:2]} >= 32'(DEPTH));

  always_comb begin
    w_be       = 4'b0000;
    w_misalign = 1'b0;
    case (hsize)
      3'd0: w_be = 4'b0001 << haddr[1:0];
      3'd1: begin
        w_be       = haddr[1] ? 4'b1100 : 4'b0011;
        w_misalign = haddr[0];
      end
      3'd2: begin
        w_be       = 4'b1111;
        w_misalign = |haddr[1:0];
      end
      default: w_misalign = 1'b1;
    endcase
  end

  assign w_illegal = w_oob || w_misalign;

  always_comb begin
    w_next          = r_state;
    w_wait_cnt_next = r_wait_cnt;
    case (r_state)
      S_IDLE, S_DATA, S_ERR2: begin
        w_next = S_IDLE;
        if (w_accept) begin
          if (w_illegal) begin
            w_next = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_next          = S_WAIT;
            w_wait_cnt_next = 2'(WAIT_STATES - 1);
          end else begin
            w_next = S_DATA;
          end
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 2'd0) begin
          w_next = S_DATA;
        end else begin
          w_wait_cnt_next = r_wait_cnt - 2'd1;
        end
      end
      S_ERR1:  w_next = S_ERR2;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 2'd0;
      r_write    <= 1'b0;
      r_be       <= 4'b0000;
      r_idx      <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_accept) begin
        r_write <= hwrite;
        r_be    <= w_be;
        r_idx   <= haddr[AW+1:2];
      end
    end
  end

  // Memory is deliberately left out of reset; a write commits on the edge ending DATA.
  always_ff @(posedge hclk) begin
    if (hresetn && (r_state == S_DATA) && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
    end
  end

  assign hreadyout   = !((r_state == S_WAIT) || (r_state == S_ERR1));
  assign hresp       = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign hrdata      = ((r_state == S_DATA) && !r_write) ? r_mem[r_idx] : 32'h0;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: directed vector table, hand-written multi-cycle sequences and
// randomized transfers checked against a byte-level memory model.
module tb_ahb_mem_slave;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        bus_sel = 1'b0;
  logic        dut_sel = 1'b1;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [31:0] hwdata = '0;

  logic        sel0, sel1, ro0, ro1, rs0, rs1, hready;
  logic [31:0] rd0, rd1;
  logic [2:0]  st0, st1;
  logic        ro, rs;
  logic [31:0] rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 hclk = ~hclk;

  assign sel1   = bus_sel & dut_sel;
  assign sel0   = bus_sel & ~dut_sel;
  assign hready = dut_sel ? ro1 : ro0;
  assign ro     = dut_sel ? ro1 : ro0;
  assign rs     = dut_sel ? rs1 : rs0;
  assign rd     = dut_sel ? rd1 : rd0;

  ahb_mem_slave #(.DEPTH(64), .WAIT_STATES(1)) u_dut1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(sel1), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(ro1), .hrdata(rd1), .hresp(rs1), .o_dbg_state(st1)
  );

  ahb_mem_slave #(.DEPTH(64), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(sel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(ro0), .hrdata(rd0), .hresp(rs0), .o_dbg_state(st0)
  );

  // Reference model: plain byte-addressed view of the 64-word memory
  logic [31:0] model_mem [64];
  logic [31:0] exp_q [$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_resp;
    int          exp_waits;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_resp, input int exp_waits);
    vec_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_resp = exp_resp; v.exp_waits = exp_waits;
    return v;
  endfunction

  function automatic bit legal(input logic [31:0] addr, input logic [2:0] size);
    if (size > 3'd2) return 1'b0;
    if ((addr / 4) >= 64) return 1'b0;
    return (addr % (32'd1 << size)) == 0;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    int lane;
    for (int b = 0; b < (1 << size); b++) begin
      lane = int'((addr + 32'(b)) % 4);
      model_mem[addr / 4][8*lane +: 8] = wdata[8*lane +: 8];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  // One non-pipelined transfer; returns the final data-phase outputs and the
  // number of stalled (hreadyout=0) cycles, plus the OR of hresp over those cycles.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic resp, output int waits, output logic wresp);
    bit done;
    done  = 1'b0;
    waits = 0;
    wresp = 1'b0;
    rdata = '0;
    resp  = 1'b0;
    @(negedge hclk);
    bus_sel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
    @(posedge hclk);
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge hclk);
      bus_sel = 1'b0; htrans = 2'b00; hwdata = wdata;
      if (ro) begin
        rdata = rd; resp = rs; done = 1'b1;
      end else begin
        waits++;
        wresp = wresp | rs;
      end
      @(posedge hclk);
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL xfer_timeout addr=%08h actual=stalled required=hreadyout_high", addr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rdata, a, w;
    logic        resp, wresp, wr;
    logic [2:0]  sz;
    int          waits;

    vecs.push_back(mk(1'b1, 32'h00, 3'd2, 32'hDEADBEEF, 32'h0,        1'b0, 1));
    vecs.push_back(mk(1'b0, 32'h00, 3'd2, 32'h0,       32'hDEADBEEF, 1'b0, 1));
    vecs.push_back(mk(1'b1, 32'h08, 3'd2, 32'h00000000, 32'h0,       1'b0, 1));
    vecs.push_back(mk(1'b1, 32'h0A, 3'd0, 32'h00AA0000, 32'h0,       1'b0, 1));
    vecs.push_back(mk(1'b1, 32'h08, 3'd1, 32'h0000C0DE, 32'h0,       1'b0, 1));
    vecs.push_back(mk(1'b0, 32'h08, 3'd2, 32'h0,       32'h00AAC0DE, 1'b0, 1));
    vecs.push_back(mk(1'b0, 32'h0B, 3'd0, 32'h0,       32'h00AAC0DE, 1'b0, 1));
    vecs.push_back(mk(1'b0, 32'h100, 3'd2, 32'h0,      32'h0,        1'b1, 1));
    vecs.push_back(mk(1'b1, 32'h02, 3'd2, 32'h11111111, 32'h0,       1'b1, 1));
    vecs.push_back(mk(1'b1, 32'h09, 3'd1, 32'h22222222, 32'h0,       1'b1, 1));
    vecs.push_back(mk(1'b1, 32'h00, 3'd3, 32'h33333333, 32'h0,       1'b1, 1));
    vecs.push_back(mk(1'b0, 32'h00, 3'd2, 32'h0,       32'hDEADBEEF, 1'b0, 1));

    // Reset
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("reset_ro1", {31'b0, ro1}, 32'd1);
    chk("reset_rs1", {31'b0, rs1}, 32'd0);
    chk("reset_rd1", rd1, 32'h0);
    chk("reset_ro0", {31'b0, ro0}, 32'd1);
    chk("reset_rs0", {31'b0, rs0}, 32'd0);
    chk("reset_rd0", rd0, 32'h0);
    hresetn = 1'b1;

    // Fill the whole memory so every later read has a known expectation
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      do_xfer(1'b1, 32'(i * 4), 3'd2, w, rdata, resp, waits, wresp);
      model_mem[i] = w;
      if (i % 16 == 0) chk("init_resp", {31'b0, resp}, 32'd0);
    end

    // Directed vector table
    foreach (vecs[k]) begin
      do_xfer(vecs[k].wr, vecs[k].addr, vecs[k].size, vecs[k].wdata, rdata, resp, waits, wresp);
      chk($sformatf("vec%0d_resp", k), {31'b0, resp}, {31'b0, vecs[k].exp_resp});
      chk($sformatf("vec%0d_waits", k), 32'(waits), 32'(vecs[k].exp_waits));
      chk($sformatf("vec%0d_stall_resp", k), {31'b0, wresp}, {31'b0, vecs[k].exp_resp});
      if (!vecs[k].wr) chk($sformatf("vec%0d_rdata", k), rdata, vecs[k].exp_rdata);
      if (vecs[k].wr && legal(vecs[k].addr, vecs[k].size))
        model_write(vecs[k].addr, vecs[k].size, vecs[k].wdata);
    end

    // IDLE / BUSY / unselected cycles carrying write-looking signals
    @(negedge hclk);
    bus_sel = 1'b1; htrans = 2'b00; hwrite = 1'b1; haddr = 32'h0; hsize = 3'd2; hwdata = 32'h12345678;
    @(negedge hclk);
    chk("idle_ro", {31'b0, ro}, 32'd1);
    chk("idle_rs", {31'b0, rs}, 32'd0);
    htrans = 2'b01;
    @(negedge hclk);
    chk("busy_ro", {31'b0, ro}, 32'd1);
    chk("busy_rs", {31'b0, rs}, 32'd0);
    bus_sel = 1'b0; htrans = 2'b10;
    @(negedge hclk);
    chk("unsel_ro", {31'b0, ro}, 32'd1);
    chk("unsel_rs", {31'b0, rs}, 32'd0);
    htrans = 2'b00;
    do_xfer(1'b0, 32'h0, 3'd2, 32'h0, rdata, resp, waits, wresp);
    chk("idle_mem_unchanged", rdata, model_mem[0]);

    // Reset arriving during the wait state of a write
    @(negedge hclk);
    bus_sel = 1'b1; htrans = 2'b10; haddr = 32'h14; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk);
    @(negedge hclk);
    bus_sel = 1'b0; htrans = 2'b00; hwdata = 32'hDEADFACE;
    chk("midrst_wait_ro", {31'b0, ro}, 32'd0);
    hresetn = 1'b0;
    @(posedge hclk);
    @(negedge hclk);
    chk("midrst_ro", {31'b0, ro}, 32'd1);
    chk("midrst_rs", {31'b0, rs}, 32'd0);
    chk("midrst_rd", rd, 32'h0);
    hresetn = 1'b1;
    do_xfer(1'b0, 32'h14, 3'd2, 32'h0, rdata, resp, waits, wresp);
    chk("midrst_mem5", rdata, model_mem[5]);

    // Randomized transfers against the model
    for (int n = 0; n < 150; n++) begin
      wr = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      a  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 1023)) : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
      w  = $urandom;
      exp_q.push_back((!wr && legal(a, sz)) ? model_mem[a / 4] : 32'h0);
      do_xfer(wr, a, sz, w, rdata, resp, waits, wresp);
      chk("rand_resp", {31'b0, resp}, {31'b0, !legal(a, sz)});
      chk("rand_waits", 32'(waits), 32'd1);
      if (!wr) chk("rand_rdata", rdata, exp_q.pop_front());
      else void'(exp_q.pop_front());
      if (wr && legal(a, sz)) model_write(a, sz, w);
    end

    // Zero-wait-state instance: pipelined write then read of the same word
    @(negedge hclk);
    dut_sel = 1'b0;
    bus_sel = 1'b1; htrans = 2'b10; haddr = 32'h14; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk);
    @(negedge hclk);
    chk("b2b_wr_ro", {31'b0, ro}, 32'd1);
    chk("b2b_wr_rs", {31'b0, rs}, 32'd0);
    haddr = 32'h14; hwrite = 1'b0; htrans = 2'b10; bus_sel = 1'b1; hwdata = 32'hFEEDFACE;
    @(posedge hclk);
    @(negedge hclk);
    chk("b2b_rd_ro", {31'b0, ro}, 32'd1);
    chk("b2b_rd_rs", {31'b0, rs}, 32'd0);
    chk("b2b_rd_data", rd, 32'hFEEDFACE);
    bus_sel = 1'b0; htrans = 2'b00; hwdata = 32'h0;
    @(posedge hclk);
    @(negedge hclk);
    chk("b2b_after_ro", {31'b0, ro}, 32'd1);
    chk("b2b_after_rd", rd, 32'h0);
    do_xfer(1'b0, 32'h14, 3'd2, 32'h0, rdata, resp, waits, wresp);
    chk("ws0_read_waits", 32'(waits), 32'd0);
    chk("ws0_read_data", rdata, 32'hFEEDFACE);
    do_xfer(1'b0, 32'h100, 3'd2, 32'h0, rdata, resp, waits, wresp);
    chk("ws0_err_waits", 32'(waits), 32'd1);
    chk("ws0_err_stall_resp", {31'b0, wresp}, 32'd1);
    chk("ws0_err_resp", {31'b0, resp}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 32-bit memory words.
REQ-002 SHALL have parameter WAIT_STATES, default 1, legal 0..3, meaning the wait cycles inserted per OKAY data phase.
REQ-003 SHALL have port hclk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port hresetn, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port hsel, input, 1, slave select from the decoder.
REQ-006 SHALL have port haddr, input, 32, byte address.
REQ-007 SHALL have port htrans, input, 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 SHALL have port hwrite, input, 1: 1 is write, 0 is read.
REQ-009 SHALL have port hsize, input, 3: 0 is byte, 1 is halfword, 2 is word.
REQ-010 SHALL have port hwdata, input, 32, write data valid in the data phase.
REQ-011 SHALL have port hready, input, 1, the bus-wide ready (mux of all hreadyout).
REQ-012 SHALL have port hreadyout, output, 1, this slave's ready.
REQ-013 SHALL have port hrdata, output, 32, read data.
REQ-014 SHALL have port hresp, output, 1: 0 is OKAY, 1 is ERROR.

Function
REQ-015 SHALL accept an address phase only on a rising edge with hsel=1, hready=1 and htrans[1]=1, then latch haddr, hwrite and hsize.
REQ-016 SHALL treat IDLE/BUSY, or hsel=0, as no transfer: no memory access, hreadyout=1, hresp=0 in the following cycle.
REQ-017 SHALL flag a transfer illegal when any of these holds, and then perform no memory access:
- haddr[31:2] >= DEPTH;
- hsize > 2;
- halfword with haddr[0]=1;
- word with haddr[1:0] != 0.
REQ-018 SHALL implement the FSM states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-019 SHALL make these FSM transitions:
- an accepted legal transfer goes to WAIT if WAIT_STATES>0, else to DATA;
- an accepted illegal transfer goes to ERR1.
REQ-020 SHALL, in WAIT, drive hreadyout=0, hresp=0 and count down WAIT_STATES cycles, then enter DATA.
REQ-021 SHALL, in DATA, drive hreadyout=1 and hresp=0 for exactly one cycle, which ends the data phase.
REQ-022 SHALL produce a two-cycle ERROR response: ERR1 drives hreadyout=0, hresp=1; ERR2 drives hreadyout=1, hresp=1.
REQ-023 SHALL, in DATA or ERR2, accept a new address phase on the same edge (pipelined back-to-back), otherwise return to IDLE.
REQ-024 SHALL commit write data on the rising edge ending DATA, using byte-lane enables (little-endian) and leaving unselected bytes unchanged:
- byte: lane haddr[1:0];
- halfword: lanes {haddr[1],0} and {haddr[1],1};
- word: all four lanes.
REQ-025 SHALL, during a read's DATA cycle, drive hrdata combinationally as the full word mem[addr_q]; it SHALL drive hrdata=0 in all other cycles.
REQ-026 SHALL return the just-written value to a read accepted on the edge that commits a write to the same word (read-after-write with no hazard).
REQ-027 SHALL ignore hwdata in all cycles except the DATA cycle of a write.
REQ-028 SHALL ignore a new address phase presented while hreadyout=0 (hready is low then).

Reset
REQ-029 SHALL, on a rising edge with hresetn=0, force the FSM to IDLE, the wait counter to 0, hreadyout=1, hresp=0 and hrdata=0.
REQ-030 SHALL, on a reset that arrives mid-transfer (WAIT/ERR1), abort the transfer with no memory write.
REQ-031 SHALL NOT reset memory contents.

Verification
REQ-032 SHALL cover word write then read: write 0xDEADBEEF to 0x00, then read 0x00 -> hrdata=0xDEADBEEF with hresp=0 and 1 wait cycle (WAIT_STATES=1).
REQ-033 SHALL cover byte and halfword lanes: word 0x00000000 at 0x08, then byte write 0xAA at 0x0A, then halfword write 0xC0DE at 0x08, then read 0x08 -> hrdata=0x00AAC0DE.
REQ-034 SHALL cover back-to-back accesses with WAIT_STATES=0: write 0xFEEDFACE to 0x14, with a read of 0x14 in the next address phase -> hrdata=0xFEEDFACE, hreadyout never low.
REQ-035 SHALL cover error responses:
- read 0x100 (DEPTH=64) -> ERR1 then ERR2 (hresp=1, hreadyout=0 then 1);
- word write at 0x02 -> same two-cycle ERROR response, memory unchanged.
REQ-036 SHALL cover IDLE/BUSY and unselected cycles: htrans=IDLE or hsel=0 with hwrite=1 and hwdata=0x12345678 -> no memory change, hreadyout=1, hresp=0.
REQ-037 SHALL cover reset mid-transfer: hresetn=0 during WAIT of a write of 0xDEADFACE to 0x14 -> outputs reset the next edge and mem[5] keeps its previous value.
